ldl_rr_dispatch_v1: RTL and testbench
=====================================

Name: ldl_rr_dispatch_v1

Overview:
- Sits directly downstream of the round-robin arbiter.
- Accepts each granted transfer (valid/ready, binary grant index plus user sideband) into a 2-entry skid buffer.
- Steers the head entry to one of REQ_WIDTH consumer channels selected by the grant index.
- Per-channel credit counters stop a consumer from being overrun; credits come back on a per-channel return strobe.

Parameters:
- BIN_WIDTH, 3, width of grant index.
- USER_WIDTH, 1, width of user sideband.
- REQ_WIDTH, 1<<BIN_WIDTH, number of consumer channels.
- CREDITS, 4, initial and maximum credits per channel (1..2^CNT_WIDTH-1).
- CNT_WIDTH, 3, credit counter width.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  upstream transfer valid.
- in_ready  output  1  buffer can accept.
- in_bin  input  BIN_WIDTH  target channel index.
- in_user  input  USER_WIDTH  sideband.
- out_valid  output  REQ_WIDTH  one-hot per-channel valid.
- out_ready  input  REQ_WIDTH  per-channel ready.
- out_user  output  USER_WIDTH  sideband of head entry, shared by all channels.
- credit_ret  input  REQ_WIDTH  per-channel credit return strobe, 1 credit per set bit per cycle.
- credit_cnt  output  REQ_WIDTH*CNT_WIDTH  current credits, channel i at [i*CNT_WIDTH +: CNT_WIDTH].
- credit_err  output  1  sticky: credit returned to a full counter.

Behaviour:
- Clock and reset: single clock clk. Reset rst is synchronous and active-high and takes priority over all other activity, including mid-transfer.
- Reset values:
  - buffer empty, in_ready=1 from the cycle after reset, out_valid=0.
  - out_user=0, every credit counter = CREDITS, credit_err=0.
- Buffer:
  - 2-entry FIFO of {bin,user} with occupancy count 0..2.
  - in_ready = (count!=2), decoded from registered state only, with no combinational path from out_ready.
  - Accept when in_valid && in_ready.
  - Simultaneous accept and dispatch at count=2 is not possible, since in_ready=0 then.
  - Simultaneous accept and dispatch at count=1 keeps count=1.
- Latency: an entry accepted in cycle N can appear on out_valid in cycle N+1 at the earliest. No combinational in->out path.
- Dispatch:
  - head_ok = (count!=0) && (credit[head_bin]!=0).
  - out_valid[i] = head_ok && (head_bin==i); at most one bit set.
  - Dispatch fires when out_valid[head_bin] && out_ready[head_bin]; the head is popped the same edge.
  - out_valid and out_user hold stable until the dispatch fires.
  - A head with zero credits blocks in order (head-of-line). No reordering.
- Credit counters, per channel i:
  - dispatch only: -1.
  - credit_ret[i] only: +1.
  - both in the same cycle: unchanged.
  - credit_ret[i] while counter==CREDITS and no dispatch to i: counter stays CREDITS, credit_err set (sticky until rst).
  - A counter never underflows, because dispatch requires credit!=0.
- Throughput: with credits available and out_ready held high, sustains 1 transfer per cycle.

Test Plan:
- Reset, then in_valid=1, in_bin=5, in_user=1 for one cycle; out_ready=all 1 -> next cycle out_valid=8'b0010_0000, out_user=1; after dispatch credit_cnt ch5 = 3.
- Back-to-back bins 0,1,2,3 every cycle with out_ready=all 1 -> in_ready stays 1 throughout, out_valid walks 0x01,0x02,0x04,0x08 on consecutive cycles.
- out_ready=0 while sending bins 2,2,2 -> in_ready falls after 2 accepts; third held; out_valid[2] stays 1 with out_user unchanged; raising out_ready drains all 3 in order.
- Send 5 transfers to bin 1 with CREDITS=4 and no returns -> 4 dispatched; 5th held with out_valid=0; pulse credit_ret[1] -> 5th dispatched the next cycle; ch1 counter ends at 0.
- Same cycle: dispatch to ch3 plus credit_ret[3] -> ch3 counter unchanged. credit_ret[6] at ch6=4 -> ch6 counter stays 4, credit_err=1 and stays 1.
- Assert rst with 2 entries buffered and ch0 counter=1 -> next cycle out_valid=0, in_ready=1, all counters=4, credit_err=0.

Source files
------------

// File: rtl/ldl_rr_dispatch_v1.sv
// Credit-gated dispatch stage behind the round-robin arbiter.
// A 2-entry skid buffer holds granted {bin,user} transfers. The head entry is
// steered to the consumer channel named by its bin. It is only offered when that
// channel still holds a credit, so the head can block the queue in order.
module ldl_rr_dispatch_v1 #(
  parameter int BIN_WIDTH  = 3,
  parameter int USER_WIDTH = 1,
  parameter int REQ_WIDTH  = 1 << BIN_WIDTH,
  parameter int CREDITS    = 4,
  parameter int CNT_WIDTH  = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [BIN_WIDTH-1:0]           in_bin,
  input  logic [USER_WIDTH-1:0]          in_user,
  output logic [REQ_WIDTH-1:0]           out_valid,
  input  logic [REQ_WIDTH-1:0]           out_ready,
  output logic [USER_WIDTH-1:0]          out_user,
  input  logic [REQ_WIDTH-1:0]           credit_ret,
  output logic [REQ_WIDTH*CNT_WIDTH-1:0] credit_cnt,
  output logic                           credit_err
);

  localparam logic [CNT_WIDTH-1:0] CRED_MAX = CNT_WIDTH'(CREDITS);
  localparam logic [CNT_WIDTH-1:0] CRED_ONE = CNT_WIDTH'(1);

  logic [BIN_WIDTH-1:0]  bin_q  [2];
  logic [USER_WIDTH-1:0] user_q [2];
  logic                  rd_ptr;
  logic                  wr_ptr;
  logic [1:0]            count;
  logic [CNT_WIDTH-1:0]  cred_q [REQ_WIDTH];
  logic                  credit_err_q;

  logic [BIN_WIDTH-1:0]  head_bin;
  logic [USER_WIDTH-1:0] head_user;
  logic                  head_ok;
  logic                  accept;
  logic                  dispatch;
  logic [REQ_WIDTH-1:0]  disp_vec;

  assign head_bin  = bin_q[rd_ptr];
  assign head_user = user_q[rd_ptr];
  assign head_ok   = (count != 2'd0) && (cred_q[head_bin] != '0);

  // in_ready comes from the registered count only, so out_ready never reaches it
  assign in_ready  = (count != 2'd2);
  assign accept    = in_valid && in_ready;
  assign dispatch  = head_ok && out_ready[head_bin];
  assign disp_vec  = out_valid & out_ready;
  assign out_user  = (count != 2'd0) ? head_user : '0;
  assign credit_err = credit_err_q;

  // One-hot valid toward the channel addressed by the head entry
  always_comb begin
    out_valid = '0;
    if (head_ok) out_valid[head_bin] = 1'b1;
  end

  // Expose the per-channel counters as one flat vector
  always_comb begin
    credit_cnt = '0;
    for (int i = 0; i < REQ_WIDTH; i++) begin
      credit_cnt[i*CNT_WIDTH +: CNT_WIDTH] = cred_q[i];
    end
  end

  // Skid buffer storage, pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        bin_q[i]  <= '0;
        user_q[i] <= '0;
      end
    end else begin
      if (accept) begin
        bin_q[wr_ptr]  <= in_bin;
        user_q[wr_ptr] <= in_user;
        wr_ptr         <= ~wr_ptr;
      end
      if (dispatch) rd_ptr <= ~rd_ptr;
      case ({accept, dispatch})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Credit counters: dispatch consumes, return restores, both together cancel.
  // A return into a full counter is dropped and latched as an error.
  always_ff @(posedge clk) begin
    if (rst) begin
      credit_err_q <= 1'b0;
      for (int i = 0; i < REQ_WIDTH; i++) cred_q[i] <= CRED_MAX;
    end else begin
      for (int i = 0; i < REQ_WIDTH; i++) begin
        if (disp_vec[i] && !credit_ret[i]) begin
          cred_q[i] <= cred_q[i] - CRED_ONE;
        end else if (credit_ret[i] && !disp_vec[i]) begin
          if (cred_q[i] == CRED_MAX) credit_err_q <= 1'b1;
          else                       cred_q[i]    <= cred_q[i] + CRED_ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_ldl_rr_dispatch_v1.sv
// Self-checking bench for ldl_rr_dispatch_v1: directed scenarios plus a
// randomized run compared against a queue-based reference model.
module tb_ldl_rr_dispatch_v1;

  localparam int NCH = 8;
  localparam int CRED = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_bin;
  logic [0:0]  in_user;
  logic [7:0]  out_valid;
  logic [7:0]  out_ready;
  logic [0:0]  out_user;
  logic [7:0]  credit_ret;
  logic [23:0] credit_cnt;
  logic        credit_err;

  int total = 0;
  int bad = 0;

  // reference model: transfer queue, per-channel credits, sticky error
  int mq_bin[$];
  int mq_user[$];
  int mcred[NCH];
  bit merr;

  ldl_rr_dispatch_v1 dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_bin(in_bin), .in_user(in_user),
    .out_valid(out_valid), .out_ready(out_ready), .out_user(out_user),
    .credit_ret(credit_ret), .credit_cnt(credit_cnt), .credit_err(credit_err)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] cnt(input int ch);
    return credit_cnt[ch*3 +: 3];
  endfunction

  function automatic logic [7:0] exp_valid();
    logic [7:0] v;
    v = 8'h00;
    if (mq_bin.size() > 0 && mcred[mq_bin[0]] > 0) v[mq_bin[0]] = 1'b1;
    return v;
  endfunction

  // advance the model by one clock using the inputs currently driven, then clock the DUT
  task automatic tick();
    int d;
    bit acc;
    if (rst) begin
      mq_bin.delete();
      mq_user.delete();
      for (int i = 0; i < NCH; i++) mcred[i] = CRED;
      merr = 1'b0;
    end else begin
      acc = in_valid && (mq_bin.size() < 2);
      d = -1;
      if (mq_bin.size() > 0 && mcred[mq_bin[0]] > 0 && out_ready[mq_bin[0]]) d = mq_bin[0];
      for (int i = 0; i < NCH; i++) begin
        if (d == i && !credit_ret[i]) mcred[i] = mcred[i] - 1;
        else if (credit_ret[i] && d != i) begin
          if (mcred[i] == CRED) merr = 1'b1;
          else mcred[i] = mcred[i] + 1;
        end
      end
      if (d >= 0) begin
        void'(mq_bin.pop_front());
        void'(mq_user.pop_front());
      end
      if (acc) begin
        mq_bin.push_back(int'(in_bin));
        mq_user.push_back(int'(in_user));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; in_bin = 3'd0; in_user = 1'b0;
    out_ready = 8'h00; credit_ret = 8'h00;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    total++; if (out_valid !== 8'h00) begin bad++; $display("FAIL reset_out_valid got=%h exp=00", out_valid); end
    total++; if (out_user !== 1'b0) begin bad++; $display("FAIL reset_out_user got=%b exp=0", out_user); end
    total++; if (credit_cnt !== {8{3'd4}}) begin bad++; $display("FAIL reset_credits got=%h exp=%h", credit_cnt, {8{3'd4}}); end
    total++; if (credit_err !== 1'b0) begin bad++; $display("FAIL reset_credit_err got=%b exp=0", credit_err); end
  endtask

  task automatic test_single();
    do_reset();
    out_ready = 8'hFF;
    in_valid = 1'b1; in_bin = 3'd5; in_user = 1'b1;
    tick();
    in_valid = 1'b0;
    total++; if (out_valid !== 8'b0010_0000) begin bad++; $display("FAIL single_out_valid got=%h exp=20", out_valid); end
    total++; if (out_user !== 1'b1) begin bad++; $display("FAIL single_out_user got=%b exp=1", out_user); end
    tick();
    total++; if (cnt(5) !== 3'd3) begin bad++; $display("FAIL single_credit5 got=%0d exp=3", cnt(5)); end
    total++; if (out_valid !== 8'h00) begin bad++; $display("FAIL single_drained got=%h exp=00", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] ev;
    do_reset();
    out_ready = 8'hFF;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; in_bin = 3'(k); in_user = 1'(k);
      tick();
      ev = 8'h00; ev[k] = 1'b1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_in_ready k=%0d got=%b exp=1", k, in_ready); end
      total++; if (out_valid !== ev) begin bad++; $display("FAIL b2b_out_valid k=%0d got=%h exp=%h", k, out_valid, ev); end
    end
    in_valid = 1'b0;
    tick();
    total++; if (out_valid !== 8'h00) begin bad++; $display("FAIL b2b_drain got=%h exp=00", out_valid); end
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 8'h00;
    in_valid = 1'b1; in_bin = 3'd2; in_user = 1'b1;
    tick();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready1 got=%b exp=1", in_ready); end
    in_user = 1'b0;
    tick();
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready2 got=%b exp=0", in_ready); end
    in_user = 1'b1;
    tick();
    tick();
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_held got=%b exp=0", in_ready); end
    total++; if (out_valid !== 8'h04) begin bad++; $display("FAIL bp_out_valid got=%h exp=04", out_valid); end
    total++; if (out_user !== 1'b1) begin bad++; $display("FAIL bp_user_stable got=%b exp=1", out_user); end
    out_ready = 8'hFF;
    tick();
    total++; if (out_user !== 1'b0) begin bad++; $display("FAIL bp_drain2_user got=%b exp=0", out_user); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_drain_ready got=%b exp=1", in_ready); end
    tick();
    in_valid = 1'b0;
    total++; if (out_user !== 1'b1 || out_valid !== 8'h04) begin bad++; $display("FAIL bp_drain3 got=%b/%h exp=1/04", out_user, out_valid); end
    tick();
    total++; if (out_valid !== 8'h00) begin bad++; $display("FAIL bp_empty got=%h exp=00", out_valid); end
    total++; if (cnt(2) !== 3'd1) begin bad++; $display("FAIL bp_credit2 got=%0d exp=1", cnt(2)); end
  endtask

  task automatic test_credit_exhaust();
    do_reset();
    out_ready = 8'hFF;
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; in_bin = 3'd1; in_user = 1'(k);
      tick();
    end
    in_valid = 1'b0;
    total++; if (out_valid !== 8'h00) begin bad++; $display("FAIL exh_blocked got=%h exp=00", out_valid); end
    total++; if (cnt(1) !== 3'd0) begin bad++; $display("FAIL exh_credit0 got=%0d exp=0", cnt(1)); end
    tick();
    total++; if (out_valid !== 8'h00) begin bad++; $display("FAIL exh_still_blocked got=%h exp=00", out_valid); end
    credit_ret = 8'h02;
    tick();
    credit_ret = 8'h00;
    total++; if (out_valid !== 8'h02) begin bad++; $display("FAIL exh_release got=%h exp=02", out_valid); end
    total++; if (out_user !== 1'b0) begin bad++; $display("FAIL exh_fifth_user got=%b exp=0", out_user); end
    tick();
    total++; if (out_valid !== 8'h00) begin bad++; $display("FAIL exh_done got=%h exp=00", out_valid); end
    total++; if (cnt(1) !== 3'd0) begin bad++; $display("FAIL exh_credit_end got=%0d exp=0", cnt(1)); end
  endtask

  task automatic test_credit_same_cycle();
    do_reset();
    out_ready = 8'hFF;
    in_valid = 1'b1; in_bin = 3'd3; in_user = 1'b0;
    tick();
    in_valid = 1'b0;
    credit_ret = 8'h08;
    tick();
    credit_ret = 8'h00;
    total++; if (cnt(3) !== 3'd4) begin bad++; $display("FAIL same_cycle_ch3 got=%0d exp=4", cnt(3)); end
    total++; if (credit_err !== 1'b0) begin bad++; $display("FAIL same_cycle_no_err got=%b exp=0", credit_err); end
    credit_ret = 8'h40;
    tick();
    credit_ret = 8'h00;
    total++; if (cnt(6) !== 3'd4) begin bad++; $display("FAIL overflow_ch6 got=%0d exp=4", cnt(6)); end
    total++; if (credit_err !== 1'b1) begin bad++; $display("FAIL overflow_err got=%b exp=1", credit_err); end
    tick();
    tick();
    total++; if (credit_err !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b exp=1", credit_err); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 8'hFF;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_bin = 3'd0; in_user = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    tick();
    out_ready = 8'h00;
    credit_ret = 8'h40;
    in_valid = 1'b1;
    tick();
    credit_ret = 8'h00;
    tick();
    in_valid = 1'b0;
    total++; if (cnt(0) !== 3'd1 || in_ready !== 1'b0 || credit_err !== 1'b1) begin
      bad++; $display("FAIL mid_setup got=cnt%0d rdy%b err%b exp=cnt1 rdy0 err1", cnt(0), in_ready, credit_err);
    end
    rst = 1'b1;
    tick();
    total++; if (out_valid !== 8'h00) begin bad++; $display("FAIL mid_rst_valid got=%h exp=00", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL mid_rst_ready got=%b exp=1", in_ready); end
    total++; if (credit_cnt !== {8{3'd4}}) begin bad++; $display("FAIL mid_rst_credits got=%h exp=%h", credit_cnt, {8{3'd4}}); end
    total++; if (credit_err !== 1'b0) begin bad++; $display("FAIL mid_rst_err got=%b exp=0", credit_err); end
    rst = 1'b0;
  endtask

  task automatic test_random();
    logic [7:0] ev;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      ev = exp_valid();
      total++; if (in_ready !== (mq_bin.size() != 2)) begin bad++; $display("FAIL rnd_in_ready c=%0d got=%b exp=%b", c, in_ready, mq_bin.size() != 2); end
      total++; if (out_valid !== ev) begin bad++; $display("FAIL rnd_out_valid c=%0d got=%h exp=%h", c, out_valid, ev); end
      if (ev != 8'h00) begin
        total++; if (out_user !== 1'(mq_user[0])) begin bad++; $display("FAIL rnd_out_user c=%0d got=%b exp=%0d", c, out_user, mq_user[0]); end
      end
      for (int i = 0; i < NCH; i++) begin
        total++; if (cnt(i) !== 3'(mcred[i])) begin bad++; $display("FAIL rnd_credit c=%0d ch=%0d got=%0d exp=%0d", c, i, cnt(i), mcred[i]); end
      end
      total++; if (credit_err !== merr) begin bad++; $display("FAIL rnd_err c=%0d got=%b exp=%b", c, credit_err, merr); end
      in_valid = ($urandom_range(0, 3) != 0);
      in_bin = 3'($urandom_range(0, 7));
      in_user = 1'($urandom_range(0, 1));
      out_ready = 8'($urandom);
      if ($urandom_range(0, 3) == 0) out_ready = 8'hFF;
      for (int i = 0; i < NCH; i++) begin
        credit_ret[i] = (mcred[i] < CRED) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 60) == 0);
      end
      tick();
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_credit_exhaust();
    test_credit_same_cycle();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
